// File: rtl/calc_pkg.sv
// Shared calculator definitions: key codes, operation-FSM states and keypad FSM states.
package calc_pkg;

  localparam logic [3:0] ADD      = 4'b1100;
  localparam logic [3:0] SUB      = 4'b1011;
  localparam logic [3:0] IGUAL    = 4'b1101;
  localparam logic [3:0] SAVE     = 4'b1111;
  localparam logic [3:0] RECOVERY = 4'b1110;
  localparam logic [3:0] KEY_NONE = 4'b1010;

  localparam logic [1:0] VALUE_A     = 2'b00;
  localparam logic [1:0] VALUE_B     = 2'b01;
  localparam logic [1:0] VALUE_IGUAL = 2'b10;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, WAIT_RELEASE} kp_state_t;

endpackage

// File: rtl/keypad_encoder_if.sv
// Keypad matrix lines plus the tecla/ready/busy handshake toward the operation block.
interface keypad_encoder_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] tecla;
  logic       ready;
  logic       busy;

  modport master (input row, output col, output tecla, output ready, output busy);
  modport slave  (output row, input col, input tecla, input ready, input busy);
endinterface

// File: rtl/scan_tick_gen.sv
// Free-running divider producing a one-cycle scan tick every CLK_DIV clocks.
module scan_tick_gen #(
  parameter int CLK_DIV = 1000
) (
  input  logic Clock,
  input  logic clearIn,
  output logic tick
);
  localparam int             CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick  = (cnt_q == LAST);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  always_ff @(posedge Clock or posedge clearIn) begin
    if (clearIn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/keypad_encoder.sv
// 4x4 keypad scanner: synchronises and debounces row returns, emits one ready pulse per keypress.
module keypad_encoder
  import calc_pkg::*;
#(
  parameter int CLK_DIV        = 1000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input logic              Clock,
  input logic              clearIn,
  keypad_encoder_if.master kp
);
  localparam int            DW        = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_TICKS);
  localparam logic [2:0]    ARM_SWEEP = 3'd4;

  function automatic logic [1:0] low_index(input logic [3:0] v);
    case (v)
      4'b1110: low_index = 2'd0;
      4'b1101: low_index = 2'd1;
      4'b1011: low_index = 2'd2;
      default: low_index = 2'd3;
    endcase
  endfunction

  function automatic logic single_low(input logic [3:0] v);
    case (v)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: single_low = 1'b1;
      default:                            single_low = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'd0:  key_code = 4'b0001;  4'd1:  key_code = 4'b0010;
      4'd2:  key_code = 4'b0011;  4'd3:  key_code = ADD;
      4'd4:  key_code = 4'b0100;  4'd5:  key_code = 4'b0101;
      4'd6:  key_code = 4'b0110;  4'd7:  key_code = SUB;
      4'd8:  key_code = 4'b0111;  4'd9:  key_code = 4'b1000;
      4'd10: key_code = 4'b1001;  4'd11: key_code = SAVE;
      4'd12: key_code = RECOVERY; 4'd13: key_code = 4'b0000;
      4'd14: key_code = IGUAL;    4'd15: key_code = KEY_NONE;
    endcase
  endfunction

  kp_state_t     state_q, state_d;
  logic [3:0]    sync1_q, rs_q;
  logic [3:0]    col_q, col_d, tecla_q, tecla_d, pat_q, pat_d;
  logic [DW-1:0] deb_q, deb_d, deb_inc;
  logic [2:0]    arm_q, arm_d;
  logic [3:0]    col_rot, code;
  logic          tick, rs_idle, armed;

  scan_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .Clock   (Clock),
    .clearIn (clearIn),
    .tick    (tick)
  );

  assign col_rot = {col_q[2:0], col_q[3]};
  assign code    = key_code(low_index(pat_q), low_index(col_q));
  assign deb_inc = deb_q + 1'b1;
  assign rs_idle = (rs_q == 4'b1111);
  // After reset a key still held must not be emitted: scanning arms only after one full empty sweep.
  assign armed   = (arm_q == ARM_SWEEP);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    tecla_d = tecla_q;
    pat_d   = pat_q;
    deb_d   = deb_q;
    arm_d   = arm_q;
    case (state_q)
      SCAN: if (tick) begin
        if (!armed) begin
          arm_d = rs_idle ? arm_q + 3'd1 : 3'd0;
          col_d = col_rot;
        end else if (single_low(rs_q)) begin
          pat_d   = rs_q;
          deb_d   = '0;
          state_d = DEBOUNCE;
        end else begin
          col_d = col_rot;
        end
      end
      DEBOUNCE: if (tick) begin
        if (rs_q != pat_q) begin
          state_d = SCAN;
          col_d   = col_rot;
        end else if (deb_inc == DEB_LAST) begin
          deb_d = '0;
          if (code == KEY_NONE) begin
            state_d = WAIT_RELEASE;
          end else begin
            // tecla loads with the transition so it is already valid while ready is high.
            tecla_d = code;
            state_d = EMIT;
          end
        end else begin
          deb_d = deb_inc;
        end
      end
      EMIT: begin
        deb_d   = '0;
        state_d = WAIT_RELEASE;
      end
      WAIT_RELEASE: if (tick) begin
        if (!rs_idle) begin
          deb_d = '0;
        end else if (deb_inc == DEB_LAST) begin
          state_d = SCAN;
          col_d   = col_rot;
        end else begin
          deb_d = deb_inc;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge Clock or posedge clearIn) begin
    if (clearIn) begin
      state_q <= SCAN;
      sync1_q <= 4'b1111;
      rs_q    <= 4'b1111;
      col_q   <= 4'b1110;
      tecla_q <= 4'b0000;
      pat_q   <= 4'b1111;
      deb_q   <= '0;
      arm_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      sync1_q <= kp.row;
      rs_q    <= sync1_q;
      col_q   <= col_d;
      tecla_q <= tecla_d;
      pat_q   <= pat_d;
      deb_q   <= deb_d;
      arm_q   <= arm_d;
    end
  end

  assign kp.col   = col_q;
  assign kp.tecla = tecla_q;
  assign kp.ready = (state_q == EMIT);
  assign kp.busy  = (state_q != SCAN);
endmodule

// File: tb/tb_keypad_encoder.sv
// Bench for keypad_encoder: contact-level keypad model, pulse scoreboard and tiny operation-FSM model.
module tb_keypad_encoder;
  import calc_pkg::*;

  localparam int CD      = 4;
  localparam int DT      = 3;
  localparam int MAX_LAT = (4 + DT) * CD + 3;

  logic        Clock = 1'b0;
  logic        clearIn;
  logic [15:0] contact;
  keypad_encoder_if kp();

  keypad_encoder #(.CLK_DIV(CD), .DEBOUNCE_TICKS(DT)) dut (
    .Clock   (Clock),
    .clearIn (clearIn),
    .kp      (kp)
  );

  always #5 Clock = ~Clock;

  // Physical matrix: a closed contact at (r,c) pulls row r low while column c is driven low.
  always_comb begin
    kp.row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (contact[r*4+c] && !kp.col[c]) kp.row[r] = 1'b0;
  end

  logic [3:0] code_tbl [16] = '{4'b0001, 4'b0010, 4'b0011, 4'b1100,
                                4'b0100, 4'b0101, 4'b0110, 4'b1011,
                                4'b0111, 4'b1000, 4'b1001, 4'b1111,
                                4'b1110, 4'b0000, 4'b1101, 4'b1010};

  int         errs = 0, checks = 0, pulses = 0, cyc = 0;
  logic [3:0] codes_q[$];
  logic [1:0] op_state = VALUE_A;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge Clock);
      #1;
    end
  endtask

  // Pulse monitor, sampling on the same edge the operation block uses.
  initial begin : monitor
    logic       prev_ready;
    logic [3:0] held;
    prev_ready = 1'b0;
    forever begin
      @(negedge Clock);
      cyc++;
      if (kp.ready === 1'b1) begin
        pulses++;
        codes_q.push_back(kp.tecla);
        check_eq("ready_one_cycle", {31'b0, prev_ready}, 32'd0);
        case (kp.tecla)
          ADD, SUB:                  if (op_state == VALUE_A) op_state = VALUE_B;
          IGUAL:                     if (op_state == VALUE_B) op_state = VALUE_IGUAL;
          SAVE, RECOVERY, KEY_NONE:  ;
          default:                   if (op_state == VALUE_IGUAL) op_state = VALUE_A;
        endcase
        prev_ready = 1'b1;
        held = kp.tecla;
        @(posedge Clock);
        #1;
        check_eq("tecla_hold", {28'b0, kp.tecla}, {28'b0, held});
      end else begin
        prev_ready = 1'b0;
      end
    end
  end

  task automatic wait_pulse(input string tag, input int p0, output int lat);
    lat = 0;
    while (pulses == p0 && lat < MAX_LAT + 4) begin
      step(1);
      lat++;
    end
    check_eq(tag, {31'b0, (pulses != p0 && lat <= MAX_LAT)}, 32'd1);
  endtask

  task automatic wait_idle(input string tag, output int n);
    n = 0;
    while (kp.busy !== 1'b0 && n < 40) begin
      step(1);
      n++;
    end
    check_eq(tag, {31'b0, kp.busy}, 32'd0);
  endtask

  task automatic hold_track(input int n, output int busy_seen, output int col_changes);
    logic [3:0] pc;
    busy_seen = 0;
    col_changes = 0;
    pc = kp.col;
    repeat (n) begin
      step(1);
      if (kp.busy === 1'b1) busy_seen = 1;
      if (kp.col !== pc) col_changes++;
      pc = kp.col;
    end
  endtask

  task automatic press_and_check(input string tag, input int r, input int c, input int hold);
    int p0, lat, n, bs, cc;
    p0 = pulses;
    contact[r*4+c] = 1'b1;
    if (r == 3 && c == 3) begin
      hold_track(hold, bs, cc);
      check_eq({tag, "_unused_busy"}, bs, 1);
      check_eq({tag, "_unused_nopulse"}, pulses - p0, 0);
    end else begin
      wait_pulse({tag, "_latency"}, p0, lat);
      if (hold > lat) step(hold - lat);
      check_eq({tag, "_count"}, pulses - p0, 1);
      check_eq({tag, "_code"}, codes_q[codes_q.size()-1], code_tbl[r*4+c]);
    end
    contact = '0;
    wait_idle({tag, "_release"}, n);
  endtask

  initial begin : main
    logic [3:0] c0, tec_before;
    int n, p0, lat, bs, cc, k, hold;
    int seq_r [4] = '{2, 0, 0, 3};
    int seq_c [4] = '{0, 3, 1, 2};

    contact = '0;
    clearIn = 1'b1;
    step(3);
    check_eq("rst_col", kp.col, 4'b1110);
    check_eq("rst_tecla", kp.tecla, 4'b0000);
    check_eq("rst_ready", kp.ready, 0);
    check_eq("rst_busy", kp.busy, 0);

    // Async reset asserted mid-count and off the clock edge.
    clearIn = 1'b0;
    step(2);
    #2 clearIn = 1'b1;
    #1;
    check_eq("arst_col", kp.col, 4'b1110);
    check_eq("arst_ready", kp.ready, 0);
    check_eq("arst_busy", kp.busy, 0);
    step(1);
    clearIn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n = 0;
      c0 = kp.col;
      while (kp.col === c0 && n < 20) begin
        @(posedge Clock);
        #1;
        n++;
      end
      check_eq("rot_period", n, CD);
    end
    check_eq("rot_col", kp.col, 4'b1011);
    step(20);

    // Clean press of "5".
    p0 = pulses;
    contact[1*4+1] = 1'b1;
    wait_pulse("k5_latency", p0, lat);
    step(40 - lat);
    check_eq("k5_count", pulses - p0, 1);
    check_eq("k5_code", codes_q[codes_q.size()-1], 4'b0101);
    contact = '0;
    wait_idle("k5_release", n);
    check_eq("k5_release_time", {31'b0, (n >= 10 && n <= 13)}, 32'd1);
    check_eq("k5_col_resume", kp.col, 4'b1011);
    step(10);

    // ADD contact bouncing once per tick, then stable.
    p0 = pulses;
    for (int i = 0; i < 5; i++) begin
      contact[0*4+3] = ~contact[0*4+3];
      step(CD);
    end
    check_eq("bounce_nopulse", pulses - p0, 0);
    step(60);
    check_eq("bounce_count", pulses - p0, 1);
    check_eq("bounce_code", codes_q[codes_q.size()-1], ADD);
    contact = '0;
    wait_idle("bounce_release", n);
    step(10);

    // Ghosting: two rows closed in one column.
    p0 = pulses;
    contact[0*4+2] = 1'b1;
    contact[1*4+2] = 1'b1;
    hold_track(40, bs, cc);
    check_eq("ghost_nopulse", pulses - p0, 0);
    check_eq("ghost_busy", bs, 0);
    check_eq("ghost_rotating", {31'b0, (cc >= 9)}, 32'd1);
    contact = '0;
    step(10);

    tec_before = kp.tecla;
    press_and_check("unused", 3, 3, 40);
    check_eq("unused_tecla", kp.tecla, tec_before);
    step(10);

    // Operation sequence 7, ADD, 2, IGUAL.
    p0 = pulses;
    for (int i = 0; i < 4; i++) begin
      press_and_check("seq", seq_r[i], seq_c[i], 40);
      step(8);
    end
    check_eq("seq_total", pulses - p0, 4);
    for (int i = 0; i < 4; i++)
      check_eq("seq_order", codes_q[codes_q.size()-4+i], code_tbl[seq_r[i]*4+seq_c[i]]);
    check_eq("op_final_state", op_state, VALUE_IGUAL);

    // Reset while held in WAIT_RELEASE.
    p0 = pulses;
    contact[2*4+1] = 1'b1;
    wait_pulse("wr_latency", p0, lat);
    step(3);
    check_eq("wr_busy_before", kp.busy, 1);
    #2 clearIn = 1'b1;
    #1;
    check_eq("wr_rst_ready", kp.ready, 0);
    check_eq("wr_rst_busy", kp.busy, 0);
    check_eq("wr_rst_tecla", kp.tecla, 4'b0000);
    step(1);
    clearIn = 1'b0;
    p0 = pulses;
    hold_track(80, bs, cc);
    check_eq("wr_held_nopulse", pulses - p0, 0);
    check_eq("wr_held_nobusy", bs, 0);
    contact = '0;
    step(30);
    press_and_check("wr_repress", 2, 1, 40);
    step(10);

    // Randomized key presses against the key-map table.
    for (int i = 0; i < 12; i++) begin
      k = $urandom_range(0, 15);
      hold = $urandom_range(MAX_LAT + 5, 60);
      press_and_check("rand", k / 4, k % 4, hold);
      step($urandom_range(4, 20));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errs, checks);
    $fatal(1);
  end
endmodule

// File: doc/keypad_encoder.md
Name: keypad_encoder

Overview:
- Scans a 4x4 matrix keypad, synchronises and debounces the row returns, and encodes the pressed key into the 4-bit key code consumed by the calculator operation FSM.
- Sits upstream of the operation block: it drives the tecla/ready pair that the operation block samples on negedge Clock. This block updates only on posedge, so both signals are stable at every sampling edge.
- Emits exactly one ready pulse per physical keypress.

Parameters:
CLK_DIV, 1000, Clock cycles per scan tick (>=4); column drive and row sampling advance once per tick.
DEBOUNCE_TICKS, 4, consecutive identical ticks required to accept a press or a release (>=1).

Ports:
Clock  input  1  system clock; all state updates on posedge.
clearIn  input  1  asynchronous, active-high reset.
row  input  4  keypad row returns, active-low (pulled up externally), asynchronous to Clock.
col  output  4  column drive, active-low, one-hot-zero (exactly one bit low).
tecla  output  4  key code of the last accepted key; held stable until the next accepted key.
ready  output  1  one-Clock-cycle pulse; tecla is valid in the same cycle.
busy  output  1  high from press detection until release is accepted (state != SCAN).

Behaviour:
- Reset (clearIn=1, async): col=4'b1110, tecla=4'b0000, ready=0, busy=0, state=SCAN, tick counter=0, debounce counter=0, synchroniser flops=4'b1111. Deasserting mid-press restarts scanning; the held key must be released and pressed again before it is emitted.
- row passes through a 2-flop synchroniser; all decisions use the synchronised value rs.
- Tick: a counter runs 0..CLK_DIV-1; tick=1 when the count is CLK_DIV-1. Decisions are made only on tick cycles.
- Key map by (row,col index), giving the code:
  r0: 1=0001, 2=0010, 3=0011, ADD=1100
  r1: 4=0100, 5=0101, 6=0110, SUB=1011
  r2: 7=0111, 8=1000, 9=1001, SAVE=1111
  r3: RECOVERY=1110, 0=0000, IGUAL=1101, unused (1010 -> never emitted)
- SCAN:
  - On a tick with rs==4'b1111: rotate col left (1110->1101->1011->0111->1110).
  - On a tick with exactly one rs bit low: latch the row index and the current col, clear the debounce counter, go to DEBOUNCE. col is held.
  - On a tick with two or more rs bits low (ghosting): treated as no key; rotate col.
- DEBOUNCE:
  - Each tick where rs equals the latched pattern increments the counter. On reaching DEBOUNCE_TICKS: if the key is the unused position, go to WAIT_RELEASE with no pulse; otherwise go to EMIT.
  - Any tick with a different pattern returns to SCAN and rotates col.
- EMIT: lasts one cycle. tecla<=code, ready=1 for that cycle, then WAIT_RELEASE.
- WAIT_RELEASE:
  - col is held. The counter clears on entry.
  - Each tick with rs==4'b1111 increments the counter; a tick with any bit low clears it.
  - At DEBOUNCE_TICKS: go to SCAN and rotate col.
  - Presses of other keys while held are ignored (no rollover).
- Latency: ready rises exactly one Clock after the tick that completes the debounce count. The maximum press-to-ready time is (4+DEBOUNCE_TICKS)*CLK_DIV+3 cycles.
- ready is never high on two consecutive cycles. Holding a key produces a single pulse.
- busy=1 in DEBOUNCE, EMIT and WAIT_RELEASE.

Decomposition:
- Shared package calc_pkg holds:
  - key code constants ADD, SUB, IGUAL, SAVE, RECOVERY, KEY_NONE=4'b1010;
  - the 2-bit operation-FSM state constants VALUE_A/VALUE_B/VALUE_IGUAL;
  - the keypad FSM state enum {SCAN, DEBOUNCE, EMIT, WAIT_RELEASE}.
- One sub-module, scan_tick_gen (parameter CLK_DIV; ports Clock, clearIn, tick), generates the tick. The key map stays a combinational function inside keypad_encoder.

Test Plan:
- All bench scenarios use CLK_DIV=4, DEBOUNCE_TICKS=3.
- Reset: hold clearIn mid-count with row=4'b1111 -> col=1110, tecla=0000, ready=0, busy=0 immediately; col rotates every 4 cycles after release.
- Clean press of "5" (row[1] low while col==1101) for 40 cycles -> exactly one ready pulse with tecla=0101. After release, busy drops 3 ticks later and scanning resumes.
- Bounce: row[0] toggles every tick for 5 ticks under col==0111, then stable -> no pulse during bounce; one pulse with tecla=1100 after 3 stable ticks.
- Ghost/unused: two rows low in one column -> no pulse and col keeps rotating. Press r3/col3 -> busy=1, no ready pulse, tecla unchanged.
- Key sequence 7, ADD, 2, IGUAL into the operation block -> pulses 0111, 1100, 0010, 1101, each exactly one cycle long, with tecla stable across each negedge; operation block ends in state 2'b10.
- Async reset while in WAIT_RELEASE with the key held -> ready/busy=0 at once; after release of clearIn the held key is not emitted until released and re-pressed.
